rank_reader: RTL and testbench

RANK_READER -- requirements
Module: rank_reader

---
 rtl/rank_reader_pkg.sv | 42 ++++
 rtl/rank_skid_buf.sv | 94 +++++++++
 rtl/rank_reader.sv | 153 +++++++++++++++
 tb/tb_rank_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rank_reader_pkg.sv
// -----------------------------------------------------------------------------
// rank_reader_pkg
//   Shared scheduler definitions used by the rank pipes and the rank reader:
//   default field widths, default PIFO capacity, the skid-buffer and head-action
//   state encodings, and a constant-friendly ceil(log2) helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package rank_reader_pkg;

  localparam int RANK_WIDTH_DEF = 16;
  localparam int META_WIDTH_DEF = 16;
  localparam int PIFO_DEPTH_DEF = 64;

  // Fill state of the two-entry skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // What the reader does with the buffer head in the current cycle.
  typedef enum logic [1:0] {
    HEAD_IDLE   = 2'd0,  // nothing buffered (or in reset)
    HEAD_HOLD   = 2'd1,  // PIFO busy, or full with stall policy
    HEAD_INSERT = 2'd2,  // head goes into the PIFO
    HEAD_DROP   = 2'd3   // PIFO full, head discarded
  } head_action_t;

  // ceil(log2(value)); 0 for value <= 1. Loop bound is constant so this is
  // usable in parameter expressions and elaborates to nothing.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : rank_reader_pkg

// File: rtl/rank_skid_buf.sv
// -----------------------------------------------------------------------------
// rank_skid_buf
//   Two-entry FIFO (head, tail) holding packed {rank, meta} entries between the
//   rank pipe output and the PIFO insert port. Strict FIFO order. A push while
//   full and a pop while empty are ignored; the caller gates both.
//
//   Ports
//     clk        in   clock, all state on rising edge
//     rst        in   synchronous active-high reset, empties the buffer
//     push       in   write push_data this cycle
//     push_data  in   WIDTH  entry to write
//     pop        in   consume the head entry this cycle
//     head_data  out  WIDTH  current head entry (undefined when empty)
//     full       out  both entries occupied
//     empty      out  no entry occupied
// -----------------------------------------------------------------------------
module rank_skid_buf
  import rank_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  assign full      = (state_q == BUF_TWO);
  assign empty     = (state_q == BUF_EMPTY);
  assign head_data = head_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          // Head leaves and the new entry takes its place; count unchanged.
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // Full: push is blocked upstream, only a pop can happen.
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the data registers are deliberately not reset; the fill state alone
  // says whether they hold anything, and consumers mask them when empty.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule : rank_skid_buf

// File: rtl/rank_reader.sv
// -----------------------------------------------------------------------------
// rank_reader
//   Pulls ranked entries from the rank pipe output into a two-entry skid
//   buffer and pushes them into a downstream PIFO. Tracks the PIFO fill level
//   from its own inserts and the PIFO's dequeue pulses; when the PIFO is full
//   the head is either dropped or held, depending on DROP_WHEN_FULL.
//
//   Ports
//     clk            in   sole clock
//     rst            in   synchronous active-high reset
//     up_valid       in   rank pipe holds a ranked entry
//     up_remove      out  pop strobe to the rank pipe (fall-through)
//     up_rank        in   RANK_WIDTH  rank of upstream head
//     up_meta        in   META_WIDTH  metadata of upstream head
//     pifo_busy      in   PIFO cannot accept an insert this cycle
//     pifo_insert    out  insert strobe to the PIFO
//     pifo_rank      out  RANK_WIDTH  rank presented with the insert
//     pifo_meta      out  META_WIDTH  metadata presented with the insert
//     pifo_deq       in   PIFO removed one entry this cycle
//     occupancy      out  tracked PIFO fill level
//     insert_count   out  CNT_WIDTH  saturating count of inserts
//     drop_count     out  CNT_WIDTH  saturating count of drops
//     underflow_err  out  sticky: dequeue seen with nothing tracked
// -----------------------------------------------------------------------------
module rank_reader
  import rank_reader_pkg::*;
#(
  parameter int RANK_WIDTH     = RANK_WIDTH_DEF,
  parameter int META_WIDTH     = META_WIDTH_DEF,
  parameter int PIFO_DEPTH     = PIFO_DEPTH_DEF,
  parameter int DROP_WHEN_FULL = 1,
  parameter int CNT_WIDTH      = 32,
  localparam int OCC_WIDTH     = clog2(PIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  output logic                  up_remove,
  input  logic [RANK_WIDTH-1:0] up_rank,
  input  logic [META_WIDTH-1:0] up_meta,
  input  logic                  pifo_busy,
  output logic                  pifo_insert,
  output logic [RANK_WIDTH-1:0] pifo_rank,
  output logic [META_WIDTH-1:0] pifo_meta,
  input  logic                  pifo_deq,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]  insert_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  underflow_err
);

  typedef struct packed {
    logic [RANK_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } entry_t;

  localparam logic [OCC_WIDTH-1:0] DEPTH_LIMIT = OCC_WIDTH'(PIFO_DEPTH);

  entry_t       up_entry;
  entry_t       head_entry;
  logic         buf_full;
  logic         buf_empty;
  logic         head_valid;
  logic         has_room;
  logic         head_drop;
  logic         head_consume;
  head_action_t head_action;

  assign up_entry   = '{rank: up_rank, meta: up_meta};
  assign head_valid = !buf_empty;

  // Fall-through pop: the rank pipe drops its entry in the same cycle we
  // assert up_remove, so the strobe must only depend on our own full flag.
  assign up_remove = up_valid && !buf_full && !rst;

  // A dequeue in this cycle frees a slot that the insert may reuse.
  assign has_room = (occupancy < DEPTH_LIMIT) || pifo_deq;

  always_comb begin
    head_action = HEAD_IDLE;
    if (!rst && head_valid) begin
      if (pifo_busy) begin
        head_action = HEAD_HOLD;
      end else if (has_room) begin
        head_action = HEAD_INSERT;
      end else if (DROP_WHEN_FULL != 0) begin
        head_action = HEAD_DROP;
      end else begin
        head_action = HEAD_HOLD;
      end
    end
  end

  assign pifo_insert  = (head_action == HEAD_INSERT);
  assign head_drop    = (head_action == HEAD_DROP);
  assign head_consume = pifo_insert || head_drop;

  assign pifo_rank = (head_valid && !rst) ? head_entry.rank : '0;
  assign pifo_meta = (head_valid && !rst) ? head_entry.meta : '0;

  rank_skid_buf #(
    .WIDTH ($bits(entry_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (up_remove),
    .push_data (up_entry),
    .pop       (head_consume),
    .head_data (head_entry),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Tracked PIFO fill level. Inserts are gated by has_room, so the count can
  // never pass PIFO_DEPTH; a dequeue with nothing tracked leaves it at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      unique case ({pifo_insert, pifo_deq})
        2'b10:   occupancy <= occupancy + OCC_WIDTH'(1);
        2'b01:   if (occupancy != '0) occupancy <= occupancy - OCC_WIDTH'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // A dequeue paired with an insert at zero is a balanced insert+deq, not an
  // underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_err <= 1'b0;
    end else if (pifo_deq && !pifo_insert && (occupancy == '0)) begin
      underflow_err <= 1'b1;
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      insert_count <= '0;
      drop_count   <= '0;
    end else begin
      if (pifo_insert && (insert_count != '1)) begin
        insert_count <= insert_count + CNT_WIDTH'(1);
      end
      if (head_drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule : rank_reader

// File: tb/tb_rank_reader.sv
// -----------------------------------------------------------------------------
// tb_rank_reader
//   Two instances: index 0 drops when full (PIFO_DEPTH 4, 3-bit counters so
//   saturation is reachable), index 1 stalls when full (PIFO_DEPTH 4, 32-bit
//   counters). Inputs are applied 1 ns after the rising edge and outputs are
//   sampled 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_rank_reader;

  localparam int RW = 16;
  localparam int MW = 16;
  localparam int OW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst           [2];
  logic          up_valid      [2];
  logic          up_remove     [2];
  logic [RW-1:0] up_rank       [2];
  logic [MW-1:0] up_meta       [2];
  logic          pifo_busy     [2];
  logic          pifo_insert   [2];
  logic [RW-1:0] pifo_rank     [2];
  logic [MW-1:0] pifo_meta     [2];
  logic          pifo_deq      [2];
  logic [OW-1:0] occupancy     [2];
  logic          underflow_err [2];
  logic [2:0]    ins_cnt0, drp_cnt0;
  logic [31:0]   ins_cnt1, drp_cnt1;

  int checks = 0;
  int errors = 0;

  rank_reader #(
    .RANK_WIDTH(RW), .META_WIDTH(MW), .PIFO_DEPTH(4), .DROP_WHEN_FULL(1), .CNT_WIDTH(3)
  ) dut_drop (
    .clk(clk), .rst(rst[0]), .up_valid(up_valid[0]), .up_remove(up_remove[0]),
    .up_rank(up_rank[0]), .up_meta(up_meta[0]), .pifo_busy(pifo_busy[0]),
    .pifo_insert(pifo_insert[0]), .pifo_rank(pifo_rank[0]), .pifo_meta(pifo_meta[0]),
    .pifo_deq(pifo_deq[0]), .occupancy(occupancy[0]), .insert_count(ins_cnt0),
    .drop_count(drp_cnt0), .underflow_err(underflow_err[0])
  );

  rank_reader #(
    .RANK_WIDTH(RW), .META_WIDTH(MW), .PIFO_DEPTH(4), .DROP_WHEN_FULL(0), .CNT_WIDTH(32)
  ) dut_stall (
    .clk(clk), .rst(rst[1]), .up_valid(up_valid[1]), .up_remove(up_remove[1]),
    .up_rank(up_rank[1]), .up_meta(up_meta[1]), .pifo_busy(pifo_busy[1]),
    .pifo_insert(pifo_insert[1]), .pifo_rank(pifo_rank[1]), .pifo_meta(pifo_meta[1]),
    .pifo_deq(pifo_deq[1]), .occupancy(occupancy[1]), .insert_count(ins_cnt1),
    .drop_count(drp_cnt1), .underflow_err(underflow_err[1])
  );

  function automatic logic [31:0] ins_of(input int d);
    return (d == 0) ? {29'd0, ins_cnt0} : ins_cnt1;
  endfunction

  function automatic logic [31:0] drp_of(input int d);
    return (d == 0) ? {29'd0, drp_cnt0} : drp_cnt1;
  endfunction

  // Advance one cycle and apply the inputs for the new cycle.
  task automatic cyc(input int d, input logic r, input logic v, input logic [RW-1:0] rk,
                     input logic [MW-1:0] mt, input logic busy, input logic deq);
    @(posedge clk);
    #1;
    rst[d]       = r;
    up_valid[d]  = v;
    up_rank[d]   = rk;
    up_meta[d]   = mt;
    pifo_busy[d] = busy;
    pifo_deq[d]  = deq;
    #1;
  endtask

  task automatic test_reset(input int d);
    cyc(d, 1'b1, 1'b1, RW'(7), MW'(7), 1'b0, 1'b0);
    checks++; if (up_remove[d] !== 1'b0) begin errors++; $display("FAIL rst_up_remove dut%0d got %b want 0", d, up_remove[d]); end
    checks++; if (pifo_insert[d] !== 1'b0) begin errors++; $display("FAIL rst_insert dut%0d got %b want 0", d, pifo_insert[d]); end
    checks++; if ({pifo_rank[d], pifo_meta[d]} !== 32'd0) begin errors++; $display("FAIL rst_data dut%0d got %h want 0", d, {pifo_rank[d], pifo_meta[d]}); end
    cyc(d, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (occupancy[d] !== 3'd0) begin errors++; $display("FAIL rst_occ dut%0d got %0d want 0", d, occupancy[d]); end
    checks++; if (ins_of(d) !== 32'd0 || drp_of(d) !== 32'd0) begin errors++; $display("FAIL rst_counts dut%0d got ins %0d drop %0d want 0 0", d, ins_of(d), drp_of(d)); end
    checks++; if (underflow_err[d] !== 1'b0) begin errors++; $display("FAIL rst_underflow dut%0d got %b want 0", d, underflow_err[d]); end
    checks++; if (pifo_insert[d] !== 1'b0) begin errors++; $display("FAIL rst_after_insert dut%0d got %b want 0", d, pifo_insert[d]); end
  endtask

  task automatic test_single();
    test_reset(0);
    cyc(0, 1'b0, 1'b1, RW'(5), MW'(16'hAB), 1'b0, 1'b0);
    checks++; if (up_remove[0] !== 1'b1) begin errors++; $display("FAIL single_remove got %b want 1", up_remove[0]); end
    checks++; if (pifo_insert[0] !== 1'b0) begin errors++; $display("FAIL single_early_insert got %b want 0", pifo_insert[0]); end
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (pifo_insert[0] !== 1'b1) begin errors++; $display("FAIL single_insert got %b want 1", pifo_insert[0]); end
    checks++; if (pifo_rank[0] !== 16'd5 || pifo_meta[0] !== 16'hAB) begin errors++; $display("FAIL single_data got %h/%h want 0005/00ab", pifo_rank[0], pifo_meta[0]); end
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (occupancy[0] !== 3'd1) begin errors++; $display("FAIL single_occ got %0d want 1", occupancy[0]); end
    checks++; if (ins_of(0) !== 32'd1) begin errors++; $display("FAIL single_ins_cnt got %0d want 1", ins_of(0)); end
    checks++; if (pifo_insert[0] !== 1'b0 || pifo_rank[0] !== 16'd0) begin errors++; $display("FAIL single_idle got %b/%h want 0/0000", pifo_insert[0], pifo_rank[0]); end
  endtask

  // Three entries arrive while the PIFO is busy for four cycles.
  task automatic test_back_to_back();
    int   idx    [8] = '{0, 1, 2, 2, 2, 2, 0, 0};
    logic vld    [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic busy   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic exp_rm [8] = '{1, 1, 0, 0, 0, 1, 0, 0};
    logic exp_ins[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    int   exp_rk [8] = '{0, 0, 0, 0, 1, 2, 3, 0};
    test_reset(0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1'b0, vld[i], RW'(idx[i] + 1), MW'((idx[i] + 1) * 17), busy[i], 1'b0);
      checks++; if (up_remove[0] !== exp_rm[i]) begin errors++; $display("FAIL b2b_remove c%0d got %b want %b", i, up_remove[0], exp_rm[i]); end
      checks++; if (pifo_insert[0] !== exp_ins[i]) begin errors++; $display("FAIL b2b_insert c%0d got %b want %b", i, pifo_insert[0], exp_ins[i]); end
      if (i >= 4) begin
        checks++; if (pifo_rank[0] !== RW'(exp_rk[i]) || pifo_meta[0] !== MW'(exp_rk[i] * 17)) begin errors++; $display("FAIL b2b_data c%0d got %h/%h want rank %0d", i, pifo_rank[0], pifo_meta[0], exp_rk[i]); end
      end
    end
    checks++; if (occupancy[0] !== 3'd3 || ins_of(0) !== 32'd3) begin errors++; $display("FAIL b2b_totals got occ %0d ins %0d want 3 3", occupancy[0], ins_of(0)); end
    // Deq alone decrements; insert together with deq leaves the level alone.
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b1, RW'(9), MW'(16'h99), 1'b0, 1'b0);
    checks++; if (occupancy[0] !== 3'd2) begin errors++; $display("FAIL deq_occ got %0d want 2", occupancy[0]); end
    checks++; if (up_remove[0] !== 1'b1) begin errors++; $display("FAIL deq_remove got %b want 1", up_remove[0]); end
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checks++; if (pifo_insert[0] !== 1'b1 || pifo_rank[0] !== 16'd9) begin errors++; $display("FAIL insdeq_insert got %b/%h want 1/0009", pifo_insert[0], pifo_rank[0]); end
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (occupancy[0] !== 3'd2 || ins_of(0) !== 32'd4) begin errors++; $display("FAIL insdeq_totals got occ %0d ins %0d want 2 4", occupancy[0], ins_of(0)); end
    checks++; if (underflow_err[0] !== 1'b0) begin errors++; $display("FAIL insdeq_underflow got %b want 0", underflow_err[0]); end
  endtask

  // Six entries into a depth-4 PIFO with drop policy, then saturate drops.
  task automatic test_drop();
    int            sent;
    logic [RW-1:0] got[$];
    test_reset(0);
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(0, 1'b0, sent < 6, RW'(10 + sent), MW'(sent), 1'b0, 1'b0);
      if (pifo_insert[0] === 1'b1) got.push_back(pifo_rank[0]);
      if (up_remove[0] === 1'b1) sent++;
    end
    checks++; if (sent != 6) begin errors++; $display("FAIL drop_sent got %0d want 6", sent); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL drop_ins_seen got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== RW'(10 + i)) begin errors++; $display("FAIL drop_order %0d got %0d want %0d", i, got[i], 10 + i); end
    end
    checks++; if (occupancy[0] !== 3'd4) begin errors++; $display("FAIL drop_occ got %0d want 4", occupancy[0]); end
    checks++; if (ins_of(0) !== 32'd4 || drp_of(0) !== 32'd2) begin errors++; $display("FAIL drop_counts got ins %0d drop %0d want 4 2", ins_of(0), drp_of(0)); end
    sent = 0;
    got.delete();
    for (int c = 0; c < 16; c++) begin
      cyc(0, 1'b0, sent < 8, RW'(40 + sent), MW'(sent), 1'b0, 1'b0);
      if (pifo_insert[0] === 1'b1) got.push_back(pifo_rank[0]);
      if (up_remove[0] === 1'b1) sent++;
    end
    checks++; if (sent != 8 || got.size() != 0) begin errors++; $display("FAIL sat_traffic got sent %0d ins %0d want 8 0", sent, got.size()); end
    checks++; if (drp_of(0) !== 32'd7) begin errors++; $display("FAIL sat_drop got %0d want 7", drp_of(0)); end
    checks++; if (ins_of(0) !== 32'd4 || occupancy[0] !== 3'd4) begin errors++; $display("FAIL sat_ins got ins %0d occ %0d want 4 4", ins_of(0), occupancy[0]); end
  endtask

  // Same traffic with stall policy: head waits for a dequeue.
  task automatic test_stall();
    int            sent;
    logic [RW-1:0] got[$];
    test_reset(1);
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(1, 1'b0, sent < 6, RW'(20 + sent), MW'(sent), 1'b0, 1'b0);
      if (pifo_insert[1] === 1'b1) got.push_back(pifo_rank[1]);
      if (up_remove[1] === 1'b1) sent++;
    end
    checks++; if (sent != 6 || got.size() != 4) begin errors++; $display("FAIL stall_traffic got sent %0d ins %0d want 6 4", sent, got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== RW'(20 + i)) begin errors++; $display("FAIL stall_order %0d got %0d want %0d", i, got[i], 20 + i); end
    end
    checks++; if (occupancy[1] !== 3'd4 || ins_of(1) !== 32'd4 || drp_of(1) !== 32'd0) begin errors++; $display("FAIL stall_totals got occ %0d ins %0d drop %0d want 4 4 0", occupancy[1], ins_of(1), drp_of(1)); end
    cyc(1, 1'b0, 1'b1, RW'(26), MW'(6), 1'b0, 1'b0);
    checks++; if (up_remove[1] !== 1'b0 || pifo_insert[1] !== 1'b0) begin errors++; $display("FAIL stall_hold got remove %b insert %b want 0 0", up_remove[1], pifo_insert[1]); end
    cyc(1, 1'b0, 1'b1, RW'(26), MW'(6), 1'b0, 1'b1);
    checks++; if (pifo_insert[1] !== 1'b1 || pifo_rank[1] !== 16'd24) begin errors++; $display("FAIL stall_deq_insert got %b/%0d want 1/24", pifo_insert[1], pifo_rank[1]); end
    cyc(1, 1'b0, 1'b1, RW'(26), MW'(6), 1'b0, 1'b0);
    checks++; if (pifo_insert[1] !== 1'b0) begin errors++; $display("FAIL stall_one_only got %b want 0", pifo_insert[1]); end
    checks++; if (occupancy[1] !== 3'd4 || ins_of(1) !== 32'd5) begin errors++; $display("FAIL stall_after_deq got occ %0d ins %0d want 4 5", occupancy[1], ins_of(1)); end
    checks++; if (up_remove[1] !== 1'b1) begin errors++; $display("FAIL stall_room got %b want 1", up_remove[1]); end
    cyc(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_underflow_and_reset();
    test_reset(0);
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (occupancy[0] !== 3'd0) begin errors++; $display("FAIL uf_occ got %0d want 0", occupancy[0]); end
    checks++; if (underflow_err[0] !== 1'b1) begin errors++; $display("FAIL uf_flag got %b want 1", underflow_err[0]); end
    cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (underflow_err[0] !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b want 1", underflow_err[0]); end
    // Buffer two entries behind a busy PIFO, then reset over them.
    cyc(0, 1'b0, 1'b1, RW'(16'h31), MW'(1), 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b1, RW'(16'h32), MW'(2), 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b1, RW'(16'h33), MW'(3), 1'b1, 1'b0);
    checks++; if (up_remove[0] !== 1'b0) begin errors++; $display("FAIL mid_full got %b want 0", up_remove[0]); end
    test_reset(0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (pifo_insert[0] !== 1'b0 || occupancy[0] !== 3'd0) begin errors++; $display("FAIL mid_discard c%0d got insert %b occ %0d want 0 0", i, pifo_insert[0], occupancy[0]); end
    end
    checks++; if (ins_of(0) !== 32'd0 || drp_of(0) !== 32'd0) begin errors++; $display("FAIL mid_counts got ins %0d drop %0d want 0 0", ins_of(0), drp_of(0)); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      up_valid[d]  = 1'b0;
      up_rank[d]   = '0;
      up_meta[d]   = '0;
      pifo_busy[d] = 1'b0;
      pifo_deq[d]  = 1'b0;
    end
    test_reset(0);
    test_reset(1);
    test_single();
    test_back_to_back();
    test_drop();
    test_stall();
    test_underflow_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rank_reader
